// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all reset channels asserted, then releases them one by one
//   clk       - single clock, rising edge
//   rst_i     - synchronous active-high reset
//   rst_req_i - synchronous soft-reset request, active-high
//   rst_o     - per-channel resets at RST_POL polarity, bit 0 released first
//   done_o    - all channels released
//   busy_o    - sequence in progress (HOLD or RELEASE)
module reset_sequencer #(
    parameter int   CHANNELS       = 4,
    parameter int   HOLD_CYCLES    = 8,
    parameter int   STAGGER_CYCLES = 4,
    parameter logic RST_POL        = 1'b1
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                rst_req_i,
    output logic [CHANNELS-1:0] rst_o,
    output logic                done_o,
    output logic                busy_o
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYCLES);
    localparam logic [SW-1:0] STAG_T = SW'(STAGGER_CYCLES - 1);
    localparam logic [CHANNELS-1:0] PMASK = {CHANNELS{RST_POL}};
    localparam logic [1:0] HOLD = 2'd0, RELEASE = 2'd1, RUN = 2'd2;
    logic [1:0]          state;
    logic [HW-1:0]       hold_cnt;
    logic [SW-1:0]       stag_cnt;
    logic [CHANNELS-1:0] rel, rel_nxt;
    logic                adv;
    // released-channel mask recovered from the output register; next mask frees one more bit
    assign rel     = rst_o ^ PMASK;
    assign rel_nxt = (rel << 1) | CHANNELS'(1);
    always_comb adv = (state == HOLD && hold_cnt == HOLD_T) || (state == RELEASE && stag_cnt == STAG_T);
    always_ff @(posedge clk) begin
        if (rst_i || rst_req_i) begin
            state    <= HOLD;
            hold_cnt <= '0;
            stag_cnt <= '0;
            rst_o    <= PMASK;
            done_o   <= 1'b0;
            busy_o   <= 1'b1;
        end else begin
            if (adv) begin
                rst_o  <= rel_nxt ^ PMASK;
                state  <= rel_nxt[CHANNELS-1] ? RUN : RELEASE;
                done_o <= rel_nxt[CHANNELS-1];
                busy_o <= ~rel_nxt[CHANNELS-1];
            end
            hold_cnt <= (state == HOLD && !adv) ? hold_cnt + HW'(1) : hold_cnt;
            stag_cnt <= (state == RELEASE) ? (adv ? '0 : stag_cnt + SW'(1)) : stag_cnt;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: random and directed restart patterns against a timing model
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1, rst_req_i = 1'b0;
    logic [3:0] rst_a;
    logic       done_a, busy_a;
    logic [0:0] rst_b;
    logic       done_b, busy_b;
    int n_cmp = 0, n_err = 0;
    int edge_n = 0, last_rs = -1000;
    always #5 clk = ~clk;
    reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(3), .RST_POL(1'b1)) dut_a (
        .clk(clk), .rst_i(rst_i), .rst_req_i(rst_req_i), .rst_o(rst_a), .done_o(done_a), .busy_o(busy_a));
    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .RST_POL(1'b0)) dut_b (
        .clk(clk), .rst_i(rst_i), .rst_req_i(rst_req_i), .rst_o(rst_b), .done_o(done_b), .busy_o(busy_b));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
        end
    endtask
    // channels released k edges after E0 (k<0 means a restart edge)
    function automatic int rel_cnt(input int k, input int h, input int s, input int c);
        int r;
        if (k < h) return 0;
        r = (k - h) / s + 1;
        return r > c ? c : r;
    endfunction
    task automatic step(input logic r, input logic q);
        int k, ra, rb;
        logic [3:0] ea;
        rst_i = r;
        rst_req_i = q;
        @(posedge clk);
        edge_n++;
        if (r || q) last_rs = edge_n;
        #1;
        k  = edge_n - (last_rs + 1);
        ra = rel_cnt(k, 8, 3, 4);
        rb = rel_cnt(k, 1, 1, 1);
        ea = 4'hF << ra;
        check("a_rst", 32'(rst_a), 32'(ea));
        check("a_done", 32'(done_a), 32'(ra == 4));
        check("a_busy", 32'(busy_a), 32'(ra != 4));
        check("b_rst", 32'(rst_b), 32'(rb == 1));
        check("b_done", 32'(done_b), 32'(rb == 1));
        check("b_busy", 32'(busy_b), 32'(rb != 1));
    endtask
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(22);
        step(1'b0, 1'b1);
        idle(12);
        step(1'b0, 1'b1);
        idle(25);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        idle(22);
        idle(1);
        step(1'b0, 1'b1);
        idle(10);
        step(1'b1, 1'b1);
        idle(22);
        for (int i = 0; i < 600; i++)
            step($urandom_range(63) == 0, $urandom_range(31) == 0);
        idle(22);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
